// File: rtl/fp64_pkg.sv
// Shared binary64 constants, classifiers and
// the accumulator control state encoding.
package fp64_pkg;

  localparam logic [10:0] EXP_INF  = 11'h7FF;
  localparam logic [63:0] QNAN     = 64'h7FF8000000000000;
  localparam logic [63:0] POS_ZERO = 64'h0000000000000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_ADD,
    S_OUT
  } acc_state_e;

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == EXP_INF) && (x[51:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == EXP_INF) && (x[51:0] == '0);
  endfunction

endpackage

// File: rtl/dp_adder.sv
// Combinational binary64 adder/subtractor,
// round-to-nearest-even, subnormals supported.
module dp_adder
  import fp64_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        op,
  output logic [63:0] y
);

  logic          sa;
  logic          sb;
  logic          a_big;
  logic          sx;
  logic          sy;
  logic [10:0]   ex;
  logic [10:0]   ey;
  logic [52:0]   mx;
  logic [52:0]   my;
  logic [10:0]   d;
  logic [5:0]    dc;
  logic [111:0]  ysh;
  logic [55:0]   y_al;
  logic [56:0]   sum;
  logic [11:0]   e12;
  logic [11:0]   lzlim;
  logic [5:0]    lz;
  logic [5:0]    sh;
  logic [55:0]   m56;
  logic [11:0]   en;
  logic          rnd;
  logic [53:0]   mr;
  logic [52:0]   mf;
  logic [11:0]   ef;

  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    n = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) n = 6'(55 - i);
    end
    return n;
  endfunction

  // Align, add magnitudes, normalise, round, then
  // override with the IEEE special-case result.
  always_comb begin
    sa    = a[63];
    sb    = b[63] ^ op;
    a_big = a[62:0] >= b[62:0];
    sx    = a_big ? sa : sb;
    sy    = a_big ? sb : sa;
    ex    = a_big ? a[62:52] : b[62:52];
    ey    = a_big ? b[62:52] : a[62:52];
    mx    = a_big ? {a[62:52] != '0, a[51:0]}
                  : {b[62:52] != '0, b[51:0]};
    my    = a_big ? {b[62:52] != '0, b[51:0]}
                  : {a[62:52] != '0, a[51:0]};
    if (ex == '0) ex = 11'd1;
    if (ey == '0) ey = 11'd1;
    d    = ex - ey;
    dc   = (d > 11'd57) ? 6'd57 : d[5:0];
    ysh  = {my, 3'b000, 56'd0} >> dc;
    y_al = {ysh[111:57], ysh[56] | (|ysh[55:0])};
    if (sx ^ sy)
      sum = {1'b0, mx, 3'b000} - {1'b0, y_al};
    else
      sum = {1'b0, mx, 3'b000} + {1'b0, y_al};
    e12   = {1'b0, ex};
    lzlim = e12 - 12'd1;
    lz    = lzc56(sum[55:0]);
    sh    = 6'd0;
    if (sum[56]) begin
      m56 = {sum[56:2], sum[1] | sum[0]};
      en  = e12 + 12'd1;
    end else begin
      sh  = ({6'd0, lz} < lzlim) ? lz : lzlim[5:0];
      m56 = sum[55:0] << sh;
      en  = e12 - {6'd0, sh};
    end
    rnd = m56[2] & (m56[1] | m56[0] | m56[3]);
    mr  = {1'b0, m56[55:3]} + {53'd0, rnd};
    if (mr[53]) begin
      mf = mr[53:1];
      ef = en + 12'd1;
    end else begin
      mf = mr[52:0];
      ef = en;
    end
    if (sum == '0)
      y = {sx & sy, 63'd0};
    else if (ef >= 12'd2047)
      y = {sx, EXP_INF, 52'd0};
    else
      y = {sx, mf[52] ? ef[10:0] : 11'd0, mf[51:0]};
    if (is_nan(a) || is_nan(b))
      y = QNAN;
    else if (is_inf(a) && is_inf(b))
      y = (sa == sb) ? {sa, EXP_INF, 52'd0} : QNAN;
    else if (is_inf(a))
      y = {sa, EXP_INF, 52'd0};
    else if (is_inf(b))
      y = {sb, EXP_INF, 52'd0};
  end

endmodule

// File: rtl/dp_accum_ctrl.sv
// Valid/ready accumulate stage folding binary64
// operands into a running sum via dp_adder.
module dp_accum_ctrl
  import fp64_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [63:0] ACC_INIT = POS_ZERO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_ovf
);

  acc_state_e       state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      opnd_q, opnd_d;
  logic             sub_q, sub_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nan_q, nan_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_nan_q, out_nan_d;
  logic             out_ovf_q, out_ovf_d;
  logic [63:0]      sum;
  logic             fin_in;

  dp_adder u_add (
    .a  (acc_q),
    .b  (opnd_q),
    .op (sub_q),
    .y  (sum)
  );

  assign fin_in = !is_inf(acc_q) && !is_nan(acc_q)
               && !is_inf(opnd_q) && !is_nan(opnd_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    sub_d       = sub_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    nan_d       = nan_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_nan_d   = out_nan_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        acc_d      = ACC_INIT;
        cnt_d      = '0;
        nan_d      = 1'b0;
        ovf_d      = 1'b0;
        state_d    = S_ACCEPT;
        in_ready_d = 1'b1;
      end
      S_ACCEPT: begin
        if (in_valid) begin
          opnd_d     = in_data;
          sub_d      = in_sub;
          last_d     = in_last;
          state_d    = S_ADD;
          in_ready_d = 1'b0;
        end
      end
      S_ADD: begin
        acc_d = sum;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        nan_d      = nan_q | is_nan(sum);
        ovf_d      = ovf_q | (is_inf(sum) & fin_in);
        state_d    = last_q ? S_OUT : S_ACCEPT;
        in_ready_d = !last_q;
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_count_d = cnt_q;
          out_nan_d   = nan_q;
          out_ovf_d   = ovf_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      acc_d       = ACC_INIT;
      opnd_d      = '0;
      sub_d       = 1'b0;
      last_d      = 1'b0;
      cnt_d       = '0;
      nan_d       = 1'b0;
      ovf_d       = 1'b0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_count_d = '0;
      out_nan_d   = 1'b0;
      out_ovf_d   = 1'b0;
    end
  end

  // State and output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= ACC_INIT;
      opnd_q      <= '0;
      sub_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_nan_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      sub_q       <= sub_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_nan_q   <= out_nan_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_nan   = out_nan_q;
  assign out_ovf   = out_ovf_q;

endmodule
